fc_engine: RTL and testbench

- Parametrised successor of the fixed 120→84→10 fully-connected stage.
- Runs a two-layer FC classifier (IN_SIZE→HID_SIZE→OUT_SIZE) on one time-shared MAC and ends with an argmax stage.
- Reads the bias and weights as a stream from single-port ROM with 1-cycle latency. Returns the winning class index with a start/done handshake.
- Sits between the CNN feature extractor and the system result register.

---
 rtl/fc_pkg.sv | 55 +++++
 rtl/fc_engine_mac.sv | 44 ++++
 rtl/fc_engine.sv | 203 ++++++++++++++++++++
 tb/tb_fc_engine.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and arithmetic helpers for fc_engine; FC_SATURATE_EN selects clamping
// instead of two's-complement wrap when results are narrowed to a word.
package fc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_WB,
        S_ARGMAX,
        S_DONE
    } state_t;

    typedef enum logic {
        L_HID,
        L_OUT
    } layer_t;

    localparam int DEF_IN_SIZE     = 120;
    localparam int DEF_HID_SIZE    = 84;
    localparam int DEF_OUT_SIZE    = 10;
    localparam int DEF_WORD_SIZE   = 16;
    localparam int DEF_FRAC_BITS   = 11;
    localparam int DEF_ADDR_W      = 14;
    localparam int DEF_WEIGHT_BASE = 0;

    function automatic int acc_width(input int word_size, input int fanin);
        return 2 * word_size + $clog2(fanin + 1);
    endfunction

    function automatic int hid_base(input int weight_base);
        return weight_base;
    endfunction

    function automatic int out_base(input int weight_base, input int in_size, input int hid_size);
        return weight_base + hid_size * (in_size + 1);
    endfunction

    function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v, input int ws);
`ifdef FC_SATURATE_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ws - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ws - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
`else
        return (v <<< (64 - ws)) >>> (64 - ws);
`endif
    endfunction

endpackage

// File: rtl/fc_engine_mac.sv
// fc_mac_unit: signed multiply-accumulate with bias load; result is activated then narrowed
// combinationally from the accumulator plus the current product. No backpressure.
module fc_mac_unit
    import fc_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int ACC_W     = acc_width(DEF_WORD_SIZE, DEF_IN_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_vld,
    input  logic                        i_bias,
    input  logic                        i_relu,
    input  logic signed [WORD_SIZE-1:0] i_data,
    input  logic signed [WORD_SIZE-1:0] i_operand,
    output logic signed [WORD_SIZE-1:0] o_result
);

    logic signed [2*WORD_SIZE-1:0] w_prod;
    logic signed [ACC_W-1:0]       r_acc;
    logic signed [ACC_W-1:0]       w_sum;
    logic signed [ACC_W-1:0]       w_shift;
    logic signed [ACC_W-1:0]       w_act;

    assign w_prod  = i_data * i_operand;
    assign w_sum   = r_acc + ACC_W'(w_prod);
    assign w_shift = w_sum >>> FRAC_BITS;
    // ReLU acts on the full-width value so wrap-around cannot flip a large positive result
    assign w_act    = (i_relu && w_shift[ACC_W-1]) ? '0 : w_shift;
    assign o_result = WORD_SIZE'(sat_narrow(64'(w_act), WORD_SIZE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_vld) begin
            if (i_bias)
                r_acc <= ACC_W'(i_data) <<< FRAC_BITS;
            else
                r_acc <= w_sum;
        end
    end

endmodule

// File: rtl/fc_engine.sv
// fc_engine: two-layer FC classifier on one MAC plus argmax; FC_SATURATE_EN enables clamping.
// Latency 1 + HID*(IN+2) + OUT*(HID+2) + OUT cycles from start to done; start ignored when busy.
module fc_engine
    import fc_pkg::*;
#(
    parameter int IN_SIZE           = DEF_IN_SIZE,
    parameter int HID_SIZE          = DEF_HID_SIZE,
    parameter int OUT_SIZE          = DEF_OUT_SIZE,
    parameter int WORD_SIZE         = DEF_WORD_SIZE,
    parameter int FRAC_BITS         = DEF_FRAC_BITS,
    parameter int MEM_ADDRESS_WIDTH = DEF_ADDR_W,
    parameter int WEIGHT_BASE       = DEF_WEIGHT_BASE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [IN_SIZE*WORD_SIZE-1:0]  fc_inputs,
    input  logic [WORD_SIZE-1:0]          mem_data,
    output logic [MEM_ADDRESS_WIDTH-1:0]  mem_addr,
    output logic                          mem_rd,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(OUT_SIZE)-1:0]   class_out,
    output logic [WORD_SIZE-1:0]          max_score
);

    localparam int MAX_F    = (IN_SIZE > HID_SIZE) ? IN_SIZE : HID_SIZE;
    localparam int MAX_N    = (HID_SIZE > OUT_SIZE) ? HID_SIZE : OUT_SIZE;
    localparam int CW       = $clog2(MAX_F + 1);
    localparam int NW       = $clog2(MAX_N + 1);
    localparam int CLS_W    = $clog2(OUT_SIZE);
    localparam int ACC_W    = acc_width(WORD_SIZE, MAX_F);
    localparam int HID_BASE = hid_base(WEIGHT_BASE);
    localparam int OUT_BASE = out_base(WEIGHT_BASE, IN_SIZE, HID_SIZE);

    state_t                           r_state;
    layer_t                           r_layer;
    logic [CW-1:0]                    r_cnt;
    logic [NW-1:0]                    r_neur;
    logic [MEM_ADDRESS_WIDTH-1:0]     r_addr;
    logic                             r_rd;
    logic                             r_busy;
    logic                             r_done;
    logic [CLS_W-1:0]                 r_class;
    logic signed [WORD_SIZE-1:0]      r_max;
    logic [CLS_W-1:0]                 r_bidx;
    logic signed [WORD_SIZE-1:0]      r_best;
    logic signed [WORD_SIZE-1:0]      r_in  [IN_SIZE];
    logic signed [WORD_SIZE-1:0]      r_hid [HID_SIZE];
    logic signed [WORD_SIZE-1:0]      r_out [OUT_SIZE];
    // Read-side controls delayed one cycle to line up with the ROM data
    logic                             r_d_vld;
    logic                             r_d_bias;
    logic [CW-1:0]                    r_d_idx;

    logic [CW-1:0]                    w_fanin_last;
    logic [NW-1:0]                    w_neur_last;
    logic signed [WORD_SIZE-1:0]      w_operand;
    logic signed [WORD_SIZE-1:0]      w_cand;
    logic signed [WORD_SIZE-1:0]      w_result;
    logic                             w_take;

    assign w_fanin_last = (r_layer == L_HID) ? CW'(IN_SIZE) : CW'(HID_SIZE);
    assign w_neur_last  = (r_layer == L_HID) ? NW'(HID_SIZE - 1) : NW'(OUT_SIZE - 1);
    assign w_take       = (r_neur == '0) || (w_cand > r_best);

    always_comb begin
        w_operand = '0;
        for (int i = 0; i < IN_SIZE; i++)
            if (r_layer == L_HID && r_d_idx == CW'(i))
                w_operand = r_in[i];
        for (int i = 0; i < HID_SIZE; i++)
            if (r_layer == L_OUT && r_d_idx == CW'(i))
                w_operand = r_hid[i];
    end

    always_comb begin
        w_cand = '0;
        for (int i = 0; i < OUT_SIZE; i++)
            if (r_neur == NW'(i))
                w_cand = r_out[i];
    end

    fc_mac_unit #(
        .WORD_SIZE (WORD_SIZE),
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (ACC_W)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .i_vld     (r_d_vld),
        .i_bias    (r_d_bias),
        .i_relu    (r_layer == L_HID),
        .i_data    (mem_data),
        .i_operand (w_operand),
        .o_result  (w_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_layer  <= L_HID;
            r_cnt    <= '0;
            r_neur   <= '0;
            r_addr   <= '0;
            r_rd     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_class  <= '0;
            r_max    <= '0;
            r_bidx   <= '0;
            r_best   <= '0;
            r_d_vld  <= 1'b0;
            r_d_bias <= 1'b0;
            r_d_idx  <= '0;
            for (int i = 0; i < IN_SIZE; i++)  r_in[i]  <= '0;
            for (int i = 0; i < HID_SIZE; i++) r_hid[i] <= '0;
            for (int i = 0; i < OUT_SIZE; i++) r_out[i] <= '0;
        end else begin
            r_done   <= 1'b0;
            r_d_vld  <= r_rd;
            r_d_bias <= (r_state == S_MAC) && (r_cnt == '0);
            r_d_idx  <= r_cnt - CW'(1);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < IN_SIZE; i++)
                            r_in[i] <= fc_inputs[i*WORD_SIZE +: WORD_SIZE];
                        r_state <= S_MAC;
                        r_layer <= L_HID;
                        r_cnt   <= '0;
                        r_neur  <= '0;
                        r_addr  <= MEM_ADDRESS_WIDTH'(HID_BASE);
                        r_rd    <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_MAC: begin
                    if (r_cnt == w_fanin_last) begin
                        r_rd    <= 1'b0;
                        r_state <= S_WB;
                    end else begin
                        r_cnt  <= r_cnt + CW'(1);
                        r_addr <= r_addr + MEM_ADDRESS_WIDTH'(1);
                    end
                end
                S_WB: begin
                    for (int i = 0; i < HID_SIZE; i++)
                        if (r_layer == L_HID && r_neur == NW'(i))
                            r_hid[i] <= w_result;
                    for (int i = 0; i < OUT_SIZE; i++)
                        if (r_layer == L_OUT && r_neur == NW'(i))
                            r_out[i] <= w_result;
                    r_cnt <= '0;
                    if (r_neur != w_neur_last) begin
                        r_neur  <= r_neur + NW'(1);
                        r_addr  <= r_addr + MEM_ADDRESS_WIDTH'(1);
                        r_rd    <= 1'b1;
                        r_state <= S_MAC;
                    end else if (r_layer == L_HID) begin
                        r_layer <= L_OUT;
                        r_neur  <= '0;
                        r_addr  <= MEM_ADDRESS_WIDTH'(OUT_BASE);
                        r_rd    <= 1'b1;
                        r_state <= S_MAC;
                    end else begin
                        r_neur  <= '0;
                        r_state <= S_ARGMAX;
                    end
                end
                S_ARGMAX: begin
                    if (w_take) begin
                        r_best <= w_cand;
                        r_bidx <= r_neur[CLS_W-1:0];
                    end
                    if (r_neur == NW'(OUT_SIZE - 1)) begin
                        r_class <= w_take ? r_neur[CLS_W-1:0] : r_bidx;
                        r_max   <= w_take ? w_cand : r_best;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_neur <= r_neur + NW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = r_addr;
    assign mem_rd    = r_rd;
    assign busy      = r_busy;
    assign done      = r_done;
    assign class_out = r_class;
    assign max_score = r_max;

endmodule

// File: tb/tb_fc_engine.sv
// Directed bench for fc_engine at IN=4, HID=3, OUT=2, Q8 arithmetic, with a 1-cycle ROM model.
module tb_fc_engine;

    localparam int IN  = 4;
    localparam int HID = 3;
    localparam int OUT = 2;
    localparam int W   = 16;
    localparam int FB  = 8;
    localparam int AW  = 14;
    localparam int LAT = 1 + HID * (IN + 2) + OUT * (HID + 2) + OUT;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [IN*W-1:0] fc_inputs;
    logic [W-1:0]    mem_data = '0;
    logic [AW-1:0]   mem_addr;
    logic            mem_rd;
    logic            busy;
    logic            done;
    logic [0:0]      class_out;
    logic [W-1:0]    max_score;

    logic [W-1:0]    rom [32];
    int              errors = 0;
    int              checks = 0;

    typedef struct packed {
        logic [W-1:0] in0, in1, in2, in3;
        logic [W-1:0] hb, hw0, hwr;
        logic [W-1:0] ob0, ow0, ob1;
        logic         exp_cls;
        logic [W-1:0] exp_max;
    } vec_t;

    vec_t tbl [7];

    fc_engine #(
        .IN_SIZE           (IN),
        .HID_SIZE          (HID),
        .OUT_SIZE          (OUT),
        .WORD_SIZE         (W),
        .FRAC_BITS         (FB),
        .MEM_ADDRESS_WIDTH (AW),
        .WEIGHT_BASE       (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .fc_inputs (fc_inputs),
        .mem_data  (mem_data),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .busy      (busy),
        .done      (done),
        .class_out (class_out),
        .max_score (max_score)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_rd) mem_data <= rom[mem_addr[4:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every hidden neuron gets the same bias/weights; only output neuron 0 sees hidden 0
    task automatic load_vec(input vec_t v);
        for (int i = 0; i < 32; i++) rom[i] = '0;
        for (int n = 0; n < HID; n++) begin
            rom[n*5]     = v.hb;
            rom[n*5 + 1] = v.hw0;
            for (int k = 2; k < 5; k++) rom[n*5 + k] = v.hwr;
        end
        rom[15]   = v.ob0;
        rom[16]   = v.ow0;
        rom[19]   = v.ob1;
        fc_inputs = {v.in3, v.in2, v.in1, v.in0};
    endtask

    // Called at a negedge in IDLE; returns the cycle index at which done is seen
    task automatic run(output int lat);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int exp_addr;
        int last_addr;
        int nreads;
        int ndone;

        tbl[0] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0, 16'h0200, 1'b1, 16'h0200};
        tbl[1] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0180, 16'h0, 16'h0180, 1'b0, 16'h0180};
        tbl[2] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'hFF00, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0001, 1'b1, 16'h0001};
        tbl[3] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'hFF00, 16'h0, 16'h0, 16'h0, 16'h0100, 16'hFFFF, 1'b0, 16'h0000};
        tbl[4] = '{16'h0200, 16'h0100, 16'hFF00, 16'h0080, 16'h0080, 16'h0200, 16'h0100,
                   16'h0, 16'h0100, 16'h0, 1'b0, 16'h0500};
`ifdef FC_SATURATE_EN
        tbl[5] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0, 16'h7FFF, 16'h7FFF,
                   16'h0, 16'h0100, 16'h8000, 1'b0, 16'h7FFF};
`else
        tbl[5] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0, 16'h7FFF, 16'h7FFF,
                   16'h0, 16'h0100, 16'h8000, 1'b0, 16'hFC00};
`endif
        tbl[6] = '{16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0,
                   16'h0, 16'hFF80, 16'hFFFE, 1'b0, 16'hFFFF};

        rst = 1'b1;
        start = 1'b0;
        load_vec(tbl[0]);
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_class", 32'(class_out), 32'd0);
        check("rst_max", 32'(max_score), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            load_vec(tbl[i]);
            run(lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(LAT));
            check($sformatf("v%0d_class", i), 32'(class_out), 32'(tbl[i].exp_cls));
            check($sformatf("v%0d_max", i), 32'(max_score), 32'(tbl[i].exp_max));
            check($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
        end

        // Repeated start pulses during a run, plus the ROM address stream
        load_vec(tbl[0]);
        exp_addr = 0; last_addr = 0; nreads = 0; ndone = 0;
        start = 1'b1;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = 1'b0;
                check("seq_busy_c1", 32'(busy), 32'd1);
            end
            if (cyc == 5 || cyc == 31) start = 1'b1;
            if (cyc == 6 || cyc == 32) start = 1'b0;
            if (mem_rd) begin
                check($sformatf("seq_addr_c%0d", cyc), 32'(mem_addr), 32'(exp_addr));
                last_addr = exp_addr;
                exp_addr++;
                nreads++;
            end else if (cyc >= 2) begin
                check($sformatf("seq_hold_c%0d", cyc), 32'(mem_addr), 32'(last_addr));
            end
            if (done) begin
                ndone++;
                check("seq_done_cycle", 32'(cyc), 32'(LAT));
            end
        end
        check("seq_reads", 32'(nreads), 32'd23);
        check("seq_done_count", 32'(ndone), 32'd1);

        // Reset in the middle of a run aborts without a done pulse
        load_vec(tbl[0]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 2; cyc <= 10; cyc++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mem_rd", 32'(mem_rd), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_class", 32'(class_out), 32'd0);
        rst = 1'b0;
        ndone = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        run(lat);
        check("after_abort_latency", 32'(lat), 32'(LAT));
        check("after_abort_class", 32'(class_out), 32'd1);
        check("after_abort_max", 32'(max_score), 32'h0200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
